// File: rtl/series_datapath.sv
// series_datapath: fixed-point registers and arithmetic for the cosh(x) Taylor series.
// Holds X (operand), T (running term), R (accumulated result) and C (coefficient index).
// T and R saturate instead of wrapping.
module series_datapath #(
  parameter int W     = 16,
  parameter int FRAC  = 14,
  parameter int CW    = 4,
  parameter int NITER = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] x_in,
  input  logic         zx,
  input  logic         initx,
  input  logic         ldx,
  input  logic         zt,
  input  logic         initt,
  input  logic         ldt,
  input  logic         zr,
  input  logic         initr,
  input  logic         ldr,
  input  logic         zc,
  input  logic         ldc,
  input  logic         enc,
  input  logic         s0,
  input  logic         s1,
  output logic         co,
  output logic [W-1:0] result
);

  localparam int                      ONE_I = 1 << FRAC;
  localparam logic signed [W-1:0]     ONE   = W'(ONE_I);
  localparam logic signed [W-1:0]     MAXV  = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]     MINV  = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [2*W-1:0]   MAX2  = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0]   MIN2  = {{(W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic [CW-1:0]           CLAST = CW'(2 * NITER);

  logic signed [W-1:0] x_q, x_d;
  logic signed [W-1:0] t_q, t_d;
  logic signed [W-1:0] r_q, r_d;
  logic [CW-1:0]       c_q, c_d;

  // Reciprocal LUT: entry k holds round(ONE/(k+1)), built at elaboration time.
  logic signed [W-1:0] coef_lut [2**CW];
  for (genvar k = 0; k < 2**CW; k++) begin : g_coef
    localparam int D = k + 1;
    assign coef_lut[k] = W'((ONE_I + D / 2) / D);
  end

  logic signed [W-1:0]   m_op;
  logic signed [2*W-1:0] prod, prod_sh;
  logic signed [W-1:0]   t_mul;
  logic signed [W:0]     sum;
  logic signed [W-1:0]   r_add;

  // Multiplier operand select from {s1,s0}.
  always_comb begin
    m_op = '0;
    unique case ({s1, s0})
      2'b00:   m_op = x_q;
      2'b01:   m_op = coef_lut[c_q];
      2'b10:   m_op = ONE;
      default: m_op = '0;
    endcase
  end

  // T*M rescaled by FRAC (arithmetic shift floors toward -inf), then clamped to W bits.
  always_comb begin
    prod    = t_q * m_op;
    prod_sh = prod >>> FRAC;
    if (prod_sh > MAX2)      t_mul = MAXV;
    else if (prod_sh < MIN2) t_mul = MINV;
    else                     t_mul = prod_sh[W-1:0];
  end

  // R+T in W+1 bits; top two bits disagreeing means the W-bit result overflowed.
  always_comb begin
    sum   = {r_q[W-1], r_q} + {t_q[W-1], t_q};
    r_add = (sum[W] != sum[W-1]) ? (sum[W] ? MINV : MAXV) : sum[W-1:0];
  end

  // Next-state selection per register: zero beats init beats load.
  always_comb begin
    x_d = x_q;
    if (zx)         x_d = '0;
    else if (initx) x_d = ONE;
    else if (ldx)   x_d = x_in;

    t_d = t_q;
    if (zt)         t_d = '0;
    else if (initt) t_d = ONE;
    else if (ldt)   t_d = t_mul;

    r_d = r_q;
    if (zr)         r_d = '0;
    else if (initr) r_d = ONE;
    else if (ldr)   r_d = r_add;

    c_d = c_q;
    if (zc || ldc)  c_d = '0;
    else if (enc)   c_d = c_q + 1'b1;
  end

  // Operand register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) x_q <= '0;
    else     x_q <= x_d;
  end

  // Running term register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) t_q <= '0;
    else     t_q <= t_d;
  end

  // Accumulated result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_q <= '0;
    else     r_q <= r_d;
  end

  // Coefficient index counter; wraps naturally at 2**CW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) c_q <= '0;
    else     c_q <= c_d;
  end

  assign co     = (c_q == CLAST);
  assign result = r_q;

endmodule

// File: tb/tb_series_datapath.sv
// Directed bench for series_datapath: reset, series runs for x = 0, +1.0, -1.0,
// strobe priority, saturation and counter wrap.
module tb_series_datapath;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] x_in;
  logic zx, initx, ldx, zt, initt, ldt, zr, initr, ldr, zc, ldc, enc, s0, s1;
  logic         co;
  logic [W-1:0] result;

  int errs   = 0;
  int checks = 0;

  series_datapath #(.W(16), .FRAC(14), .CW(4), .NITER(4)) dut (
    .clk(clk), .rst(rst), .x_in(x_in),
    .zx(zx), .initx(initx), .ldx(ldx),
    .zt(zt), .initt(initt), .ldt(ldt),
    .zr(zr), .initr(initr), .ldr(ldr),
    .zc(zc), .ldc(ldc), .enc(enc),
    .s0(s0), .s1(s1),
    .co(co), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    zx = 0; initx = 0; ldx = 0; zt = 0; initt = 0; ldt = 0;
    zr = 0; initr = 0; ldr = 0; zc = 0; ldc = 0; enc = 0; s0 = 0; s1 = 0;
  endtask

  // Apply the currently driven strobes on one rising edge, then release them.
  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic setup_run(input logic [W-1:0] xv);
    x_in = xv; ldx = 1; initt = 1; initr = 1; zc = 1;
    tick();
  endtask

  // One controller iteration: two multiplies by X, two by COEF[C] with enc, then accumulate.
  task automatic iter(input int n, input logic neg, input int exp_r, input logic exp_co);
    ldt = 1; tick();
    if (neg) chk($sformatf("it%0d_tneg", n), 32'(dut.t_q[W-1]), 1);
    ldt = 1; tick();
    if (neg) chk($sformatf("it%0d_tpos", n), 32'(dut.t_q[W-1]), 0);
    ldt = 1; s0 = 1; enc = 1; tick();
    ldt = 1; s0 = 1; enc = 1; tick();
    chk($sformatf("it%0d_co", n), 32'(co), 32'(exp_co));
    ldr = 1; tick();
    chk($sformatf("it%0d_r", n), $signed(result), exp_r);
  endtask

  initial begin
    clr();
    rst = 1; x_in = '0;
    #12;
    chk("rst_result", $signed(result), 0);
    chk("rst_co", 32'(co), 0);
    rst = 0;

    // x = 0: every accumulate leaves R at 1.0; co only on the last iteration.
    setup_run(16'd0);
    iter(1, 0, 16384, 0);
    iter(2, 0, 16384, 0);
    iter(3, 0, 16384, 0);
    iter(4, 0, 16384, 1);

    // Start a run, then reset asynchronously mid-iteration with C nonzero.
    setup_run(16'd16384);
    ldt = 1; tick();
    ldt = 1; s0 = 1; enc = 1; tick();
    #2 rst = 1;
    #1;
    chk("arst_x", $signed(dut.x_q), 0);
    chk("arst_t", $signed(dut.t_q), 0);
    chk("arst_r", $signed(result), 0);
    chk("arst_c", 32'(dut.c_q), 0);
    chk("arst_co", 32'(co), 0);
    #1 rst = 0;

    // x = +1.0: cosh(1) ~ 1.54308.
    setup_run(16'd16384);
    iter(1, 0, 24576, 0);
    iter(2, 0, 25258, 0);
    iter(3, 0, 25280, 0);
    iter(4, 0, 25280, 1);

    // x = -1.0: even function, same R; T goes negative after the first multiply.
    setup_run(16'hC000);
    iter(1, 1, 24576, 0);
    iter(2, 1, 25258, 0);
    iter(3, 1, 25280, 0);
    iter(4, 1, 25280, 1);

    // Priority on T, R and C.
    zt = 1; initt = 1; ldt = 1; tick();
    chk("prio_t", $signed(dut.t_q), 0);
    initt = 1; tick();
    initr = 1; ldr = 1; tick();
    chk("prio_r", $signed(result), 16384);
    enc = 1; tick();
    zc = 1; enc = 1; tick();
    chk("prio_c", 32'(dut.c_q), 0);
    zx = 1; initx = 1; ldx = 1; x_in = 16'd5; tick();
    chk("prio_x", $signed(dut.x_q), 0);

    // Saturation: build T=32000 and R=32000, then overflow both.
    x_in = 16'd32000; ldx = 1; initt = 1; zr = 1; tick();
    ldt = 1; tick();
    chk("sat_tset", $signed(dut.t_q), 32000);
    ldr = 1; tick();
    chk("sat_rset", $signed(result), 32000);
    x_in = 16'd32767; ldx = 1; ldr = 1; tick();
    chk("sat_r", $signed(result), 32767);
    ldt = 1; tick();
    chk("sat_t", $signed(dut.t_q), 32767);
    x_in = 16'h8000; ldx = 1; tick();
    ldt = 1; tick();
    chk("sat_tneg", $signed(dut.t_q), -32768);

    // Counter: co decodes C==8 only; 16th enc wraps to 0.
    zc = 1; tick();
    for (int i = 1; i <= 15; i++) begin
      enc = 1; tick();
      chk($sformatf("cnt_co%0d", i), 32'(co), (i == 8) ? 1 : 0);
    end
    chk("cnt_15", 32'(dut.c_q), 15);
    enc = 1; tick();
    chk("cnt_wrap", 32'(dut.c_q), 0);
    chk("cnt_wrap_co", 32'(co), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
